// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - funct codes, widths and FSM state type for the EX multiply/divide unit
package ex_muldiv_pkg;

    localparam int DATA_W  = 32;
    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1a;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1b;
    localparam logic [FUNCT_W-1:0] FUNCT_ADDU  = 6'h21;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } muldiv_state_t;

    function automatic logic is_muldiv_op(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) ||
               (f == FUNCT_DIVU) || (f == FUNCT_MTHI)  || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage request / HI-LO result bundle for the multiply/divide unit
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic               en;
    logic [FUNCT_W-1:0] funct;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic               flush;
    logic               stall_req;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output en, funct, operand_a, operand_b, flush,
        input  stall_req, hi, lo
    );

    modport slave (
        input  en, funct, operand_a, operand_b, flush,
        output stall_req, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_div_core.sv
// rtl/ex_muldiv_div_core.sv - radix-2 restoring divider datapath, one quotient bit per step
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             count_last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
    logic             neg_quo, neg_rem;
    logic [WIDTH:0]   partial, diff;
    logic [WIDTH-1:0] rem_next, quo_next, a_mag, b_mag;
    logic             fits;

    assign count_last = (count == CW'(WIDTH - 1));

    // quo_q shifts dividend bits out the top while quotient bits enter at the bottom
    assign partial  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = partial - {1'b0, divisor_q};
    assign fits     = ~diff[WIDTH];
    assign rem_next = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], fits};

    // results are taken from the step in flight so the final bit lands at the same edge
    assign quotient  = neg_quo ? -quo_next : quo_next;
    assign remainder = neg_rem ? -rem_next : rem_next;

    assign a_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
        end else if (start) begin
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            divisor_q <= b_mag;
            neg_quo   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem   <= signed_op & dividend[WIDTH-1];
        end else if (step) begin
            count     <= count + 1'b1;
            rem_q     <= rem_next;
            quo_q     <= quo_next;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX multiply/divide unit owning HI/LO: single-cycle multiply, iterative divide
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    muldiv_state_t      state;
    logic               accept, is_div, div_by_zero, start_div, step;
    logic               count_last;
    logic [WIDTH-1:0]   quotient, remainder;
    logic [2*WIDTH-1:0] a_ext, b_ext, product;

    assign accept      = (state == ST_IDLE) && bus.en && !bus.flush && is_muldiv_op(bus.funct);
    assign is_div      = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
    assign div_by_zero = (bus.operand_b == '0);
    assign start_div   = accept && is_div && !div_by_zero;
    assign step        = (state == ST_DIV) && !bus.flush;

    // the last divide cycle releases the pipeline while the result is written
    assign bus.stall_req = start_div || (step && !count_last);

    always_comb begin
        a_ext = {{WIDTH{1'b0}}, bus.operand_a};
        b_ext = {{WIDTH{1'b0}}, bus.operand_b};
        if (bus.funct == FUNCT_MULT) begin
            a_ext = {{WIDTH{bus.operand_a[WIDTH-1]}}, bus.operand_a};
            b_ext = {{WIDTH{bus.operand_b[WIDTH-1]}}, bus.operand_b};
        end
        product = a_ext * b_ext;
    end

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .start      (start_div),
        .step       (step),
        .signed_op  (bus.funct == FUNCT_DIV),
        .dividend   (bus.operand_a),
        .divisor    (bus.operand_b),
        .count_last (count_last),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.funct)
                            FUNCT_MULT, FUNCT_MULTU: {bus.hi, bus.lo} <= product;
                            FUNCT_MTHI: bus.hi <= bus.operand_a;
                            FUNCT_MTLO: bus.lo <= bus.operand_a;
                            FUNCT_DIV, FUNCT_DIVU: begin
                                if (div_by_zero) begin
                                    bus.lo <= '1;
                                    bus.hi <= bus.operand_a;
                                end else begin
                                    state <= ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DIV: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (count_last) begin
                        bus.lo <= quotient;
                        bus.hi <= remainder;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - randomized self-checking bench for ex_muldiv against an arithmetic HI/LO model
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [5:0]   codes [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int exp_stall);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        exp_stall = 0;
        case (f)
            FUNCT_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            FUNCT_MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            FUNCT_DIV, FUNCT_DIVU: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    if (f == FUNCT_DIV) begin
                        p = sa / sb;  m_lo = p[31:0];
                        p = sa % sb;  m_hi = p[31:0];
                    end else begin
                        up = ua / ub; m_lo = up[31:0];
                        up = ua % ub; m_hi = up[31:0];
                    end
                    exp_stall = W;
                end
            end
            FUNCT_MTHI: m_hi = a;
            FUNCT_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int flush_at = -1, input int rst_at = -1);
        int exp_stall, n, k;
        logic [W-1:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        @(negedge clk);
        bus.en = 1'b1; bus.funct = f; bus.operand_a = a; bus.operand_b = b; bus.flush = 1'b0;
        #1;
        n = bus.stall_req ? 1 : 0;
        model_op(f, a, b, exp_stall);
        @(negedge clk);
        bus.en = 1'b0;
        k = 0;
        while (bus.stall_req && n < 100) begin
            if (k == flush_at) begin
                bus.flush = 1'b1;
                #1;
                check({tag, " flush_stall"}, 64'(bus.stall_req), 64'd0);
                @(negedge clk);
                bus.flush = 1'b0;
                bus.en = 1'b0;
                check({tag, " flush_idle_stall"}, 64'(bus.stall_req), 64'd0);
                check({tag, " flush_hi"}, 64'(bus.hi), 64'(old_hi));
                check({tag, " flush_lo"}, 64'(bus.lo), 64'(old_lo));
                m_hi = old_hi;
                m_lo = old_lo;
                return;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, " rst_hi"}, 64'(bus.hi), 64'd0);
                check({tag, " rst_lo"}, 64'(bus.lo), 64'd0);
                check({tag, " rst_stall"}, 64'(bus.stall_req), 64'd0);
                m_hi = '0;
                m_lo = '0;
                @(negedge clk);
                rst = 1'b0;
                bus.en = 1'b0;
                return;
            end
            n++;
            k++;
            bus.en        = 1'($urandom);
            bus.funct     = codes[$urandom_range(0, 7)];
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
            @(negedge clk);
        end
        bus.en = 1'b0;
        check({tag, " stall_cycles"}, 64'(n), 64'(exp_stall));
        if (exp_stall != 0) @(negedge clk);
        check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    initial begin
        logic [5:0] f;
        logic [W-1:0] a, b;
        codes = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                  FUNCT_MTHI, FUNCT_MTLO, FUNCT_ADDU, 6'h00};
        rst = 1'b1;
        bus.en = 1'b0; bus.funct = '0; bus.operand_a = '0; bus.operand_b = '0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_stall", 64'(bus.stall_req), 64'd0);
        rst = 1'b0;

        run_op("mult_neg",   FUNCT_MULT,  32'hFFFF_FFFD, 32'd5);
        run_op("multu_max",  FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_op("divu_100_7", FUNCT_DIVU,  32'd100, 32'd7);
        run_op("div_7_m2",   FUNCT_DIV,   32'd7, 32'hFFFF_FFFE);
        run_op("div_min_m1", FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_by0",   FUNCT_DIVU,  32'd5, 32'd0);
        run_op("mthi",       FUNCT_MTHI,  32'h0000_1234, 32'd0);
        run_op("mtlo",       FUNCT_MTLO,  32'hCAFE_0001, 32'd0);
        run_op("divu_flush", FUNCT_DIVU,  32'hDEAD_BEEF, 32'd3, 10);
        run_op("div_after",  FUNCT_DIV,   32'hFFFF_FF9C, 32'd7);

        // accept cycle flush and non-muldiv funct must both leave state untouched
        @(negedge clk);
        bus.en = 1'b1; bus.funct = FUNCT_MTHI; bus.operand_a = 32'h5555_AAAA; bus.flush = 1'b1;
        #1;
        check("idle_flush_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        bus.funct = FUNCT_ADDU; bus.flush = 1'b0;
        #1;
        check("addu_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        bus.en = 1'b0;
        check("idle_noop_hi", 64'(bus.hi), 64'(m_hi));
        check("idle_noop_lo", 64'(bus.lo), 64'(m_lo));
        check("idle_noop_stall", 64'(bus.stall_req), 64'd0);

        run_op("div_rst", FUNCT_DIV, 32'h1234_5678, 32'd9, -1, 20);
        run_op("post_rst_divu", FUNCT_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 60; i++) begin
            f = codes[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%02h", i, f), f, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
